// File: rtl/ram1_arbiter.sv
// RAM1/UART bus arbiter with a posted-write buffer.
// Chooses one of IF fetch, MEM access or buffer drain each cycle.
module ram1_arbiter #(
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_req_i,
  input  logic [15:0]                 if_addr_i,
  input  logic                        mem_read_i,
  input  logic                        mem_write_i,
  input  logic [15:0]                 mem_addr_i,
  input  logic [15:0]                 mem_wdata_i,
  output logic [15:0]                 if_inst_o,
  output logic [15:0]                 mem_rdata_o,
  output logic                        stall_o,
  output logic [$clog2(WB_DEPTH):0]   wb_level_o,
  output logic [17:0]                 addr_o,
  output logic [15:0]                 data_o,
  output logic                        is_RAM1_o,
  output logic                        is_UART_o,
  output logic                        isread_o,
  output logic                        iswrite_o,
  input  logic [15:0]                 ram1res_i
);

  localparam int AW = $clog2(WB_DEPTH);
  localparam logic [15:0] UART_DATA = 16'hBF00;
  localparam logic [15:0] UART_STAT = 16'hBF01;

  logic [15:0] wb_addr [WB_DEPTH];
  logic [15:0] wb_data [WB_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0] level;
  logic [15:0] last_addr;
  logic [15:0] last_data;
  logic [15:0] cur_addr;
  logic [15:0] cur_data;

  logic mem_rd, mem_wr, uart_d, uart_s;
  logic wr_ram, wr_ud, wr_st, take_mem;
  logic empty, full, push, pop;
  logic g_drain, g_mrd, g_uwr, g_if, active, mem_done;

  assign mem_rd   = mem_read_i & ~mem_write_i;
  assign mem_wr   = mem_write_i & ~mem_read_i;
  assign uart_d   = mem_addr_i == UART_DATA;
  assign uart_s   = mem_addr_i == UART_STAT;
  assign wr_ram   = mem_wr & ~uart_d & ~uart_s;
  assign wr_ud    = mem_wr & uart_d;
  assign wr_st    = mem_wr & uart_s;
  assign take_mem = mem_rd | wr_ud;

  assign empty = level == '0;
  assign full  = level == (AW+1)'(WB_DEPTH);

  // One-hot grants; terms are disjoint so the priority order is implicit.
  assign g_drain = rst & ~empty
                 & (take_mem | (wr_ram & full) | ~if_req_i);
  assign g_mrd   = rst & mem_rd & empty;
  assign g_uwr   = rst & wr_ud & empty;
  assign g_if    = rst & if_req_i & ~take_mem & ~(wr_ram & full);
  assign active  = g_drain | g_mrd | g_uwr | g_if;

  assign push = rst & wr_ram & ~full;
  assign pop  = g_drain;

  assign mem_done = g_mrd | g_uwr | push | wr_st;
  assign stall_o  = rst
                  & (((mem_rd | mem_wr) & ~mem_done)
                  | (if_req_i & ~g_if));

  always_comb begin
    is_RAM1_o = 1'b0;
    is_UART_o = 1'b0;
    isread_o  = 1'b0;
    iswrite_o = 1'b0;
    cur_addr  = last_addr;
    cur_data  = last_data;
    unique case (1'b1)
      g_drain: begin
        is_RAM1_o = 1'b1;
        iswrite_o = 1'b1;
        cur_addr  = wb_addr[head];
        cur_data  = wb_data[head];
      end
      g_mrd: begin
        is_RAM1_o = ~(uart_d | uart_s);
        is_UART_o = uart_d | uart_s;
        isread_o  = 1'b1;
        cur_addr  = mem_addr_i;
      end
      g_uwr: begin
        is_UART_o = 1'b1;
        iswrite_o = 1'b1;
        cur_addr  = mem_addr_i;
        cur_data  = mem_wdata_i;
      end
      g_if: begin
        is_RAM1_o = 1'b1;
        isread_o  = 1'b1;
        cur_addr  = if_addr_i;
      end
      default: ;
    endcase
  end

  assign addr_o      = {2'b00, cur_addr};
  assign data_o      = cur_data;
  assign wb_level_o  = level;
  assign if_inst_o   = ram1res_i;
  assign mem_rdata_o = ram1res_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      level     <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (active) begin
        last_addr <= cur_addr;
        last_data <= cur_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= mem_addr_i;
      wb_data[tail] <= mem_wdata_i;
    end
  end

endmodule
